vec_load_unit: RTL



---
 rtl/vec_pkg.sv | 6 +
 rtl/vec_load_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/vec_pkg.sv
// vec_pkg: shared widths and load FSM state encoding
package vec_pkg;
  localparam int SEL_W = 4;
  localparam int LEN_W = 8;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, WRITE} load_state_t;
endpackage

// File: rtl/vec_load_unit.sv
// vec_load_unit: collects a streamed element load into one parallel vector bank write
module vec_load_unit
  import vec_pkg::*;
#(
  parameter int BITS = 8,
  parameter int N    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [BITS-1:0]  s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  output logic [BITS-1:0]  out_vec [N-1:0],
  output logic [LEN_W-1:0] out_len,
  output logic [SEL_W-1:0] out_sel,
  output logic             write,
  output logic             busy,
  output logic             err
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [LEN_W-1:0] NL = LEN_W'(N);
  load_state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [LEN_W-1:0] len_q, len_d, eff_q, eff_d, cnt_q, cnt_d, beats_q, beats_d;
  logic big_q, big_d, err_q, err_d;
  logic [BITS-1:0] vec_q [N-1:0];
  logic [BITS-1:0] vec_d [N-1:0];
  assign cmd_ready = state_q == IDLE;
  assign s_ready   = state_q == LOAD || state_q == DRAIN;
  assign write     = state_q == WRITE;
  assign busy      = state_q != IDLE;
  assign out_vec   = vec_q;
  assign out_len   = cnt_q;
  assign out_sel   = sel_q;
  assign err       = err_q;
  // next-state: command latch, element capture and overflow drain
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    eff_d   = eff_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    big_d   = big_q;
    err_d   = err_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        sel_d   = cmd_sel;
        len_d   = cmd_len;
        big_d   = cmd_len > NL;
        err_d   = cmd_len > NL;
        eff_d   = cmd_len > NL ? NL : cmd_len;
        cnt_d   = '0;
        beats_d = '0;
        vec_d   = '{default: '0};
        state_d = cmd_len == '0 ? WRITE : LOAD;
      end
      LOAD: if (s_valid) begin
        vec_d[cnt_q[IW-1:0]] = s_data;
        cnt_d   = cnt_q + LEN_W'(1);
        beats_d = beats_q + LEN_W'(1);
        if (cnt_q == eff_q - LEN_W'(1)) state_d = big_q && !s_last ? DRAIN : WRITE;
        else if (s_last) begin
          err_d   = 1'b1;
          state_d = WRITE;
        end
      end
      DRAIN: if (s_valid) begin
        beats_d = beats_q + LEN_W'(1);
        if (s_last || beats_q + LEN_W'(1) == len_q) state_d = WRITE;
      end
      WRITE: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any load in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      len_q   <= '0;
      eff_q   <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
      big_q   <= 1'b0;
      err_q   <= 1'b0;
      vec_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      eff_q   <= eff_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      big_q   <= big_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
    end
  end
endmodule
